jc_phase_stepper: RTL

//  Parametrised successor to the fixed 6-step clock/stepper pair. Generates the four-phase
//  CPU clock (clk, clkd, clke, clks) as registered levels and a one-hot step bus of NSTEPS.

---
 rtl/jc_clk_pkg.sv | 20 ++
 rtl/jc_quarter_gen.sv | 50 +++++
 rtl/jc_phase_stepper.sv | 92 +++++++++
 3 files changed

// File: rtl/jc_clk_pkg.sv
// Shared definitions for the four-phase CPU clock: quarter encoding and the
// per-quarter levels of the clk and clkd phases.
package jc_clk_pkg;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quarter_t;

   // Bit n is the level of the phase during quarter n.
   localparam logic [3:0] CLK_Q  = 4'b0011;
   localparam logic [3:0] CLKD_Q = 4'b0110;

   function automatic quarter_t quarter_inc(input quarter_t q);
      return quarter_t'(q + 2'd1);
   endfunction

endpackage

// File: rtl/jc_quarter_gen.sv
// Quarter-phase prescaler and quarter counter. Exposes the current and next
// quarter so the top level can decode its outputs from next-state values.
module jc_quarter_gen
   import jc_clk_pkg::*;
#(
   parameter int PHASE_DIV = 1
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     i_en,
   output quarter_t o_q,
   output quarter_t o_q_next,
   output logic     o_tick
);

   localparam int            CW      = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(PHASE_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_next;
   quarter_t      r_q;

   always_comb begin
      w_cnt_next = r_cnt;
      o_q_next   = r_q;
      o_tick     = 1'b0;
      if (i_en) begin
         if (r_cnt == CNT_MAX) begin
            o_tick     = 1'b1;
            w_cnt_next = '0;
            o_q_next   = quarter_inc(r_q);
         end else begin
            w_cnt_next = r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_q   <= Q0;
      end else begin
         r_cnt <= w_cnt_next;
         r_q   <= o_q_next;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/jc_phase_stepper.sv
// Four-phase CPU clock and one-hot step sequencer with prescaler, early wrap
// on last, and stall. All outputs are registered from next-state values.
module jc_phase_stepper
   import jc_clk_pkg::*;
#(
   parameter int NSTEPS    = 6,
   parameter int PHASE_DIV = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      last,
   output logic                      o_clk,
   output logic                      o_clkd,
   output logic                      o_clke,
   output logic                      o_clks,
   output logic [NSTEPS-1:0]         step,
   output logic [$clog2(NSTEPS)-1:0] step_idx,
   output logic                      cyc_start
);

   localparam int            SW     = $clog2(NSTEPS);
   localparam logic [SW-1:0] S_LAST = SW'(NSTEPS - 1);

   logic              r_started;
   logic [SW-1:0]     r_s;
   logic [SW-1:0]     w_s_next;
   logic              w_en;
   logic              w_tick;
   logic              w_adv;
   logic              w_wrap;
   logic              w_cyc_next;
   logic [NSTEPS-1:0] w_step_next;
   quarter_t          w_q;
   quarter_t          w_q_next;

   // The first unstalled edge after reset re-enters step 1 / quarter 0 instead
   // of advancing, so that cycle carries cyc_start like every later wrap.
   assign w_en = r_started & ~stall;

   jc_quarter_gen #(
      .PHASE_DIV (PHASE_DIV)
   ) u_qgen (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_en),
      .o_q      (w_q),
      .o_q_next (w_q_next),
      .o_tick   (w_tick)
   );

   always_comb begin
      w_wrap   = last | (r_s == S_LAST);
      w_adv    = w_tick & (w_q == Q3);
      w_s_next = r_s;
      if (w_adv) begin
         w_s_next = w_wrap ? '0 : r_s + SW'(1);
      end
      w_cyc_next = (~r_started & ~stall) | (w_adv & w_wrap);
   end

   generate
      for (genvar gi = 0; gi < NSTEPS; gi++) begin : g_step
         assign w_step_next[gi] = (w_s_next == SW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_started <= 1'b0;
         r_s       <= '0;
         o_clk     <= 1'b1;
         o_clkd    <= 1'b0;
         o_clke    <= 1'b1;
         o_clks    <= 1'b0;
         step      <= NSTEPS'(1);
         step_idx  <= '0;
         cyc_start <= 1'b0;
      end else begin
         r_started <= r_started | ~stall;
         r_s       <= w_s_next;
         o_clk     <= CLK_Q[w_q_next];
         o_clkd    <= CLKD_Q[w_q_next];
         o_clke    <= CLK_Q[w_q_next] | CLKD_Q[w_q_next];
         o_clks    <= CLK_Q[w_q_next] & CLKD_Q[w_q_next];
         step      <= w_step_next;
         step_idx  <= w_s_next;
         cyc_start <= w_cyc_next;
      end
   end

endmodule
